// File: rtl/mem_rd_window_buf_pkg.sv
// Shared types and constants for the RAM read-window buffer and its read controller.
package mem_rd_window_buf_pkg;

  localparam int unsigned DW_DEF     = 8;
  localparam int unsigned RD_LAT_DEF = 1;
  localparam int unsigned WIN_DEF    = 3;
  localparam int unsigned CW_DEF     = 8;

  // Burst lengths issued by the read controller
  localparam int unsigned BURST_LEN_238 = 238;
  localparam int unsigned BURST_LEN_154 = 154;
  localparam int unsigned BURST_LEN_108 = 108;
  localparam int unsigned BURST_LEN_54  = 54;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } winState_t;

endpackage

// File: rtl/mem_rd_window_buf_if.sv
// Read-side bus between the read controller/RAM and the window buffer, plus the window output.
interface mem_rd_window_buf_if
  import mem_rd_window_buf_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned WIN = WIN_DEF,
  parameter int unsigned CW  = CW_DEF
);
  logic              iEN_RC;
  logic [CW-1:0]     iRADDR;
  logic [DW-1:0]     iRDATA;
  logic              iFLUSH;
  logic [WIN*DW-1:0] oWIN;
  logic              oWIN_VALID;
  logic              oBURST_DONE;
  logic [CW-1:0]     oBURST_CNT;
  logic              oERR;

  modport master (
    output iEN_RC, iRADDR, iRDATA, iFLUSH,
    input  oWIN, oWIN_VALID, oBURST_DONE, oBURST_CNT, oERR
  );

  modport slave (
    input  iEN_RC, iRADDR, iRDATA, iFLUSH,
    output oWIN, oWIN_VALID, oBURST_DONE, oBURST_CNT, oERR
  );
endinterface

// File: rtl/mem_rd_window_buf_rd_lat_pipe.sv
// Delays {enable, address} by DEPTH cycles so they line up with synchronous-RAM read data.
module rd_lat_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CW    = 8
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iCLR,
  input  logic          iEN,
  input  logic [CW-1:0] iADDR,
  output logic          oEN,
  output logic [CW-1:0] oADDR
);

  logic [DEPTH-1:0] enPipe;
  logic [CW-1:0]    addrPipe [DEPTH];

  always_ff @(posedge iCLK) begin
    if (!iRST_N || iCLR) begin
      enPipe <= '0;
      for (int i = 0; i < int'(DEPTH); i++) addrPipe[i] <= '0;
    end else begin
      enPipe[0]   <= iEN;
      addrPipe[0] <= iADDR;
      for (int i = 1; i < int'(DEPTH); i++) begin
        enPipe[i]   <= enPipe[i-1];
        addrPipe[i] <= addrPipe[i-1];
      end
    end
  end

  assign oEN   = enPipe[DEPTH-1];
  assign oADDR = addrPipe[DEPTH-1];

endmodule

// File: rtl/mem_rd_window_buf.sv
// Aligns RAM read data to its delayed enable, builds a sliding window of WIN samples,
// and reports per-burst completion, length and address-sequence errors.
module mem_rd_window_buf
  import mem_rd_window_buf_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF,
  parameter int unsigned WIN    = WIN_DEF,
  parameter int unsigned CW     = CW_DEF
) (
  input  logic                iCLK,
  input  logic                iRST_N,
  mem_rd_window_buf_if.slave  bus
);

  localparam int unsigned FW = $clog2(WIN + 1);

  logic              cap;
  logic [CW-1:0]     capAddr;
  winState_t         state;
  logic [FW-1:0]     fill;
  logic [CW-1:0]     prevAddr;
  logic [CW-1:0]     burstCnt;
  logic [WIN*DW-1:0] winReg;
  logic              winValid;
  logic              burstDone;
  logic              errFlag;

  rd_lat_pipe #(
    .DEPTH (RD_LAT),
    .CW    (CW)
  ) uLatPipe (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iCLR   (bus.iFLUSH),
    .iEN    (bus.iEN_RC),
    .iADDR  (bus.iRADDR),
    .oEN    (cap),
    .oADDR  (capAddr)
  );

  // Burst FSM with window shift register, fill/burst counters and sticky error
  always_ff @(posedge iCLK) begin
    if (!iRST_N || bus.iFLUSH) begin
      state     <= IDLE;
      fill      <= '0;
      prevAddr  <= '0;
      burstCnt  <= '0;
      winReg    <= '0;
      winValid  <= 1'b0;
      burstDone <= 1'b0;
      errFlag   <= 1'b0;
    end else begin
      winValid  <= 1'b0;
      burstDone <= 1'b0;
      if (cap) begin
        winReg   <= {winReg[(WIN-1)*DW-1:0], bus.iRDATA};
        prevAddr <= capAddr;
      end
      case (state)
        IDLE, DONE: begin
          if (cap) begin
            state    <= FILL;
            fill     <= FW'(1);
            burstCnt <= CW'(1);
          end else begin
            state <= IDLE;
          end
        end
        FILL, STREAM: begin
          if (cap) begin
            if (capAddr != prevAddr + CW'(1)) errFlag <= 1'b1;
            if (burstCnt != '1) burstCnt <= burstCnt + CW'(1);
            // Window becomes full on this capture, or already was
            if (fill >= FW'(WIN - 1)) begin
              fill     <= FW'(WIN);
              winValid <= 1'b1;
              state    <= STREAM;
            end else begin
              fill <= fill + FW'(1);
            end
          end else begin
            state     <= DONE;
            burstDone <= 1'b1;
            fill      <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oWIN        = winReg;
  assign bus.oWIN_VALID  = winValid;
  assign bus.oBURST_DONE = burstDone;
  assign bus.oBURST_CNT  = burstCnt;
  assign bus.oERR        = errFlag;

endmodule
